// File: rtl/clock_period_meter_pkg.sv
// Shared types and helpers for the clock period meter and the divider family.
// Holds the measurement state encoding and the counter-width helper.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    TIMEOUT   = 2'd3
  } meter_state_e;

  // Smallest n such that 2**n >= value; also sizes the divider counters.
  function automatic int CeilLog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        n = i + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/clock_period_meter_edge_sync.sv
// Brings an asynchronous slow clock into the reference domain and reports its
// synchronized level together with single-cycle rise and fall strobes.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // SYNC_STAGES must be at least 2 so the lower slice below is well formed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow toggling input in reference-clock
// cycles, with timeout (no_signal) and frequency-lock detection.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int REFERENCE_CLOCK   = 50_000_000,
  parameter int MAX_PERIOD        = 1024,
  parameter int NBITS_FOR_COUNTER = CeilLog2(MAX_PERIOD + 1),
  parameter int SYNC_STAGES       = 2,
  parameter int LOCK_COUNT        = 4,
  parameter int TOLERANCE         = 1
) (
  input  logic                         clk_FPGA,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         signal_in,
  output logic [NBITS_FOR_COUNTER-1:0] period_out,
  output logic [NBITS_FOR_COUNTER-1:0] high_out,
  output logic                         measure_valid,
  output logic                         no_signal,
  output logic                         locked
);

  localparam int NB = NBITS_FOR_COUNTER;
  localparam int MW = CeilLog2(LOCK_COUNT + 1);
  localparam logic [NB-1:0] LAST_CNT = NB'(MAX_PERIOD - 1);
  localparam logic [NB:0]   TOL      = (NB + 1)'(TOLERANCE);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);

  logic sig_rise;
  logic sig_fall;
  logic sig_level_unused;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk_FPGA),
    .rst     (reset),
    .async_in(signal_in),
    .rise    (sig_rise),
    .fall    (sig_fall),
    .level   (sig_level_unused)
  );

  meter_state_e  state_q, state_d;
  logic [NB-1:0] cnt_q, cnt_d;
  logic [NB-1:0] high_cnt_q, high_cnt_d;
  logic [NB-1:0] period_q, period_d;
  logic [NB-1:0] high_q, high_d;
  logic [NB-1:0] prev_q, prev_d;
  logic          have_prev_q, have_prev_d;
  logic [MW-1:0] match_q, match_d;
  logic          valid_q, valid_d;
  logic          no_signal_q, no_signal_d;
  logic          locked_q, locked_d;

  logic [NB-1:0] cnt_inc;
  logic [NB:0]   diff;
  logic [NB:0]   abs_diff;
  logic [MW-1:0] match_next;
  logic          go_timeout;

  // Candidate period is cnt+1; compare against the previous one, one bit wider.
  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    diff     = {1'b0, cnt_inc} - {1'b0, prev_q};
    abs_diff = diff[NB] ? (~diff + 1'b1) : diff;
    if (have_prev_q && (abs_diff <= TOL)) begin
      match_next = (match_q == LOCK_MAX) ? match_q : match_q + 1'b1;
    end else begin
      match_next = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_cnt_d  = high_cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    valid_d     = 1'b0;
    no_signal_d = no_signal_q;
    locked_d    = locked_q;
    go_timeout  = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      high_cnt_d  = '0;
      have_prev_d = 1'b0;
      match_d     = '0;
      no_signal_d = 1'b0;
      locked_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d      = '0;
          high_cnt_d = '0;
          state_d    = WAIT_RISE;
        end
        // The partial period before the first rise is thrown away, but still
        // counted so that a dead input is caught here too.
        WAIT_RISE: begin
          if (sig_rise) begin
            cnt_d      = '0;
            high_cnt_d = '0;
            state_d    = MEASURE;
          end else if (cnt_q == LAST_CNT) begin
            go_timeout = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEASURE: begin
          if (sig_rise) begin
            period_d    = cnt_inc;
            high_d      = high_cnt_q;
            valid_d     = 1'b1;
            cnt_d       = '0;
            high_cnt_d  = '0;
            prev_d      = cnt_inc;
            have_prev_d = 1'b1;
            match_d     = match_next;
            locked_d    = (match_next == LOCK_MAX);
          end else if (cnt_q == LAST_CNT) begin
            go_timeout = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (sig_fall) begin
              high_cnt_d = cnt_inc;
            end
          end
        end
        TIMEOUT: begin
          cnt_d      = '0;
          high_cnt_d = '0;
          if (sig_rise) begin
            no_signal_d = 1'b0;
            state_d     = MEASURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Losing the signal invalidates both results and the lock history.
    if (go_timeout) begin
      state_d     = TIMEOUT;
      cnt_d       = '0;
      high_cnt_d  = '0;
      period_d    = '0;
      high_d      = '0;
      have_prev_d = 1'b0;
      match_d     = '0;
      no_signal_d = 1'b1;
      locked_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      high_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_cnt_q  <= high_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      valid_q     <= valid_d;
      no_signal_q <= no_signal_d;
      locked_q    <= locked_d;
    end
  end

  assign period_out    = period_q;
  assign high_out      = high_q;
  assign measure_valid = valid_q;
  assign no_signal     = no_signal_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized and directed bench for clock_period_meter; expected measurements
// come from a waveform-level model built from the rise times the bench drives.
module tb_clock_period_meter;
  import clock_meter_pkg::*;

  localparam int REFERENCE_CLOCK = 50_000_000;
  localparam int MAX_PERIOD      = 1024;
  localparam int NB              = CeilLog2(MAX_PERIOD + 1);
  localparam int SYNC_STAGES     = 2;
  localparam int LOCK_COUNT      = 4;
  localparam int TOLERANCE       = 1;
  localparam int LAT             = SYNC_STAGES + 1;

  typedef struct packed {
    int period;
    int high;
    bit lk;
    int cyc;
  } meas_t;

  logic          clk_FPGA;
  logic          reset;
  logic          enable;
  logic          signal_in;
  logic [NB-1:0] period_out;
  logic [NB-1:0] high_out;
  logic          measure_valid;
  logic          no_signal;
  logic          locked;

  int    total;
  int    bad;
  int    cyc;
  bit    ns_seen;
  meas_t obs_q[$];
  meas_t exp_q[$];
  int    hi_q[$];
  int    lo_q[$];

  int m_last;
  int m_hi;
  int m_prev;
  bit m_have;
  int m_match;

  clock_period_meter #(
    .REFERENCE_CLOCK  (REFERENCE_CLOCK),
    .MAX_PERIOD       (MAX_PERIOD),
    .NBITS_FOR_COUNTER(NB),
    .SYNC_STAGES      (SYNC_STAGES),
    .LOCK_COUNT       (LOCK_COUNT),
    .TOLERANCE        (TOLERANCE)
  ) dut (
    .clk_FPGA     (clk_FPGA),
    .reset        (reset),
    .enable       (enable),
    .signal_in    (signal_in),
    .period_out   (period_out),
    .high_out     (high_out),
    .measure_valid(measure_valid),
    .no_signal    (no_signal),
    .locked       (locked)
  );

  initial clk_FPGA = 1'b0;
  always #10 clk_FPGA = ~clk_FPGA;

  always @(posedge clk_FPGA) cyc <= cyc + 1;

  // Record every valid strobe, sampled half a cycle after the edge.
  always @(negedge clk_FPGA) begin
    meas_t m;
    if (measure_valid) begin
      m.period = int'(period_out);
      m.high   = int'(high_out);
      m.lk     = locked;
      m.cyc    = cyc;
      obs_q.push_back(m);
    end
    if (no_signal) ns_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got cyc=%0d want finish", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_FPGA);
    #1;
  endtask

  task automatic model_clear();
    m_last  = -1;
    m_hi    = 0;
    m_prev  = 0;
    m_have  = 1'b0;
    m_match = 0;
  endtask

  // A rise at drive cycle t closes the period that started at the last rise.
  task automatic model_rise(input int t, input int hi);
    int    gap;
    meas_t e;
    if (m_last >= 0) begin
      gap = t - m_last;
      if (gap > MAX_PERIOD) begin
        m_have  = 1'b0;
        m_match = 0;
      end else begin
        if (m_have && (gap - m_prev <= TOLERANCE) && (m_prev - gap <= TOLERANCE))
          m_match = (m_match < LOCK_COUNT) ? m_match + 1 : LOCK_COUNT;
        else
          m_match = 0;
        m_have   = 1'b1;
        m_prev   = gap;
        e.period = gap;
        e.high   = m_hi;
        e.lk     = (m_match == LOCK_COUNT);
        e.cyc    = t + LAT;
        exp_q.push_back(e);
      end
    end
    m_last = t;
    m_hi   = hi;
  endtask

  task automatic play();
    int hi;
    int lo;
    while (hi_q.size() > 0) begin
      hi = hi_q.pop_front();
      lo = lo_q.pop_front();
      signal_in = 1'b1;
      model_rise(cyc, hi);
      step(hi);
      signal_in = 1'b0;
      step(lo);
    end
  endtask

  task automatic add_seg(input int hi, input int lo);
    hi_q.push_back(hi);
    lo_q.push_back(lo);
  endtask

  task automatic restart();
    enable    = 1'b0;
    signal_in = 1'b0;
    step(4);
    obs_q.delete();
    exp_q.delete();
    model_clear();
    ns_seen = 1'b0;
    enable  = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; signal_in = 1'b0;
    step(3);
    total++; if (period_out !== '0)    begin bad++; $display("[TB] FAIL reset_period: got %0d want 0", period_out); end
    total++; if (high_out !== '0)      begin bad++; $display("[TB] FAIL reset_high: got %0d want 0", high_out); end
    total++; if (measure_valid !== 0)  begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", measure_valid); end
    total++; if (no_signal !== 0)      begin bad++; $display("[TB] FAIL reset_no_signal: got %0b want 0", no_signal); end
    total++; if (locked !== 0)         begin bad++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_divider();
    int first_lock;
    restart();
    for (int i = 0; i < 6; i++) add_seg(4, 4);
    play();
    step(2);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL divider_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL divider[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
    first_lock = -1;
    for (int i = obs_q.size() - 1; i >= 0; i--) if (obs_q[i].lk) first_lock = i;
    total++;
    if (first_lock != LOCK_COUNT) begin
      bad++; $display("[TB] FAIL divider_lock_index: got %0d want %0d", first_lock, LOCK_COUNT);
    end
    total++;
    if (period_out !== NB'(8) || high_out !== NB'(4) || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL divider_hold: got p=%0d h=%0d l=%0b want p=8 h=4 l=1", period_out, high_out, locked);
    end
  endtask

  task automatic test_jitter();
    int lows[10] = '{4, 5, 4, 6, 4, 4, 4, 4, 4, 4};
    int nlock;
    restart();
    for (int i = 0; i < 10; i++) add_seg(4, lows[i]);
    play();
    step(2);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL jitter_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL jitter[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
    nlock = 0;
    foreach (obs_q[i]) if (obs_q[i].lk) nlock++;
    total++;
    if (nlock != 1) begin
      bad++; $display("[TB] FAIL jitter_lock_count: got %0d want 1", nlock);
    end
  endtask

  task automatic test_random();
    int bhi;
    int blo;
    restart();
    bhi = $urandom_range(3, 10);
    blo = $urandom_range(3, 10);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bhi = $urandom_range(2, 12);
        blo = $urandom_range(2, 12);
      end
      add_seg(bhi, blo + int'($urandom_range(0, 1)));
    end
    play();
    step(2);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL random[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_timeout();
    int t;
    int target;
    restart();
    for (int i = 0; i < 6; i++) add_seg(4, 4);
    play();
    signal_in = 1'b1;
    t = cyc;
    model_rise(t, 4);
    target = t + LAT + MAX_PERIOD - 1;
    while (cyc < target) @(negedge clk_FPGA);
    total++;
    if (no_signal !== 1'b0 || locked !== 1'b1) begin
      bad++; $display("[TB] FAIL timeout_early: got ns=%0b l=%0b want ns=0 l=1", no_signal, locked);
    end
    @(negedge clk_FPGA);
    total++;
    if (no_signal !== 1'b1 || locked !== 1'b0 || period_out !== '0 || high_out !== '0) begin
      bad++; $display("[TB] FAIL timeout_entry: got ns=%0b l=%0b p=%0d h=%0d want ns=1 l=0 p=0 h=0",
                      no_signal, locked, period_out, high_out);
    end
    @(posedge clk_FPGA); #1;
    signal_in = 1'b0;
    step(4);
    add_seg(4, 4);
    add_seg(4, 4);
    play();
    step(2);
    total++;
    if (no_signal !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_recover: got ns=%0b want 0", no_signal);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL timeout[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_max_period(input int extra);
    restart();
    add_seg(MAX_PERIOD / 2, MAX_PERIOD / 2 + extra);
    add_seg(4, 4);
    add_seg(4, 4);
    play();
    step(2);
    total++;
    if (ns_seen !== (extra > 0)) begin
      bad++; $display("[TB] FAIL max_period_timeout(+%0d): got seen=%0b want %0b", extra, ns_seen, extra > 0);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL max_period_count(+%0d): got %0d want %0d", extra, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL max_period(+%0d)[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", extra, i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_enable_drop();
    restart();
    for (int i = 0; i < 6; i++) add_seg(4, 4);
    play();
    signal_in = 1'b1;
    model_rise(cyc, 4);
    step(4);
    signal_in = 1'b0;
    step(2);
    enable = 1'b0;
    step(1);
    total++;
    if (locked !== 1'b0 || measure_valid !== 1'b0 || no_signal !== 1'b0 || period_out !== NB'(8) || high_out !== NB'(4)) begin
      bad++; $display("[TB] FAIL enable_drop: got l=%0b v=%0b ns=%0b p=%0d h=%0d want l=0 v=0 ns=0 p=8 h=4",
                      locked, measure_valid, no_signal, period_out, high_out);
    end
    signal_in = 1'b1;
    step(2);
    enable = 1'b1;
    step(2);
    signal_in = 1'b0;
    step(4);
    model_clear();
    for (int i = 0; i < 3; i++) add_seg(4, 4);
    play();
    step(2);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL enable_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL enable[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    for (int i = 0; i < 6; i++) add_seg(4, 4);
    play();
    signal_in = 1'b1;
    step(2);
    reset = 1'b1;
    #2;
    total++;
    if (period_out !== '0 || high_out !== '0 || locked !== 1'b0 || measure_valid !== 1'b0 || no_signal !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid: got p=%0d h=%0d l=%0b v=%0b ns=%0b want all 0",
                      period_out, high_out, locked, measure_valid, no_signal);
    end
    signal_in = 1'b0;
    step(3);
    reset = 1'b0;
    step(3);
    model_clear();
    for (int i = 0; i < 3; i++) add_seg(4, 4);
    play();
    step(2);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL reset_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL reset_mid[%0d]: got p=%0d h=%0d l=%0b c=%0d want p=%0d h=%0d l=%0b c=%0d", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].lk, obs_q[i].cyc,
                 exp_q[i].period, exp_q[i].high, exp_q[i].lk, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    ns_seen = 1'b0;
    model_clear();
    reset = 1'b1;
    enable = 1'b0;
    signal_in = 1'b0;
    test_reset();
    test_divider();
    test_jitter();
    test_random();
    test_timeout();
    test_max_period(0);
    test_max_period(1);
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
